seq_alu: RTL and testbench

Parametrised, registered successor to the combinational datapath ALU. It uses the same 4-bit opcode map. It adds an iterative shift-add multiplier, a restoring divider (quotient and remainder) and a START/BUSY/DONE handshake, so the control FSM can issue multi-cycle ops. It sits between the register-file read ports and the write-back/flag register.

---
 rtl/seq_alu.sv | 224 ++++++++++++++++++++++
 tb/tb_seq_alu.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// Registered ALU with a START/BUSY/DONE handshake. Single-cycle ops finish on the accepting edge.
// MUL (shift-add) and DIV/MOD (restoring) run for WIDTH iterations.
module seq_alu #(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [3:0]       S_ALU,
    input  logic [WIDTH-1:0] DATA_A,
    input  logic [WIDTH-1:0] DATA_B,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] ALU_OUT,
    output logic [3:0]       FLAG_OUT,
    output logic             FLAG_WRITE
);
    localparam int SH_W = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_CMP = 4'b0101;
    localparam logic [3:0] OP_MOV = 4'b0110;
    localparam logic [3:0] OP_MUL = 4'b0111;
    localparam logic [3:0] OP_SLL = 4'b1000;
    localparam logic [3:0] OP_SLR = 4'b1001;
    localparam logic [3:0] OP_SRL = 4'b1010;
    localparam logic [3:0] OP_SRA = 4'b1011;
    localparam logic [3:0] OP_IDT = 4'b1100;
    localparam logic [3:0] OP_DIV = 4'b1101;
    localparam logic [3:0] OP_MOD = 4'b1110;
    localparam logic [3:0] OP_NON = 4'b1111;

    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV} state_t;

    state_t               state_reg, state_next;
    logic [3:0]           op_reg, op_next;
    logic [WIDTH-1:0]     opnd_reg, opnd_next;
    logic [2*WIDTH-1:0]   work_reg, work_next;
    logic [SH_W-1:0]      count_reg, count_next;
    logic [WIDTH-1:0]     alu_out_reg, alu_out_next;
    logic [3:0]           flag_reg, flag_next;
    logic                 done_reg, done_next;
    logic                 fw_reg, fw_next;

    // Single-cycle datapath, evaluated straight from the inputs at acceptance
    logic [SH_W-1:0]  sh_n;
    logic [WIDTH:0]   add_full, sub_full, sll_full, srl_full;
    logic [WIDTH-1:0] rot_res, sra_res;
    logic [WIDTH-1:0] sc_res;
    logic             sc_c, sc_v;

    assign sh_n     = DATA_B[SH_W-1:0];
    assign add_full = {1'b0, DATA_A} + {1'b0, DATA_B};
    assign sub_full = {1'b0, DATA_A} - {1'b0, DATA_B};
    assign sll_full = {1'b0, DATA_A} << sh_n;
    assign srl_full = {DATA_A, 1'b0} >> sh_n;
    assign sra_res  = $unsigned($signed(DATA_A) >>> sh_n);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_rot
            logic [SH_W-1:0] src;
            assign src         = SH_W'(gi) - sh_n;
            assign rot_res[gi] = DATA_A[src];
        end
    endgenerate

    always_comb begin
        sc_res = '0;
        sc_c   = 1'b0;
        sc_v   = 1'b0;
        case (S_ALU)
            OP_ADD: begin
                sc_res = add_full[WIDTH-1:0];
                sc_c   = add_full[WIDTH];
                sc_v   = (DATA_A[WIDTH-1] == DATA_B[WIDTH-1]) && (sc_res[WIDTH-1] != DATA_A[WIDTH-1]);
            end
            OP_SUB, OP_CMP: begin
                sc_res = sub_full[WIDTH-1:0];
                sc_c   = sub_full[WIDTH];
                sc_v   = (DATA_A[WIDTH-1] != DATA_B[WIDTH-1]) && (sc_res[WIDTH-1] != DATA_A[WIDTH-1]);
            end
            OP_AND:         sc_res = DATA_A & DATA_B;
            OP_OR:          sc_res = DATA_A | DATA_B;
            OP_XOR:         sc_res = DATA_A ^ DATA_B;
            OP_MOV, OP_IDT: sc_res = DATA_B;
            OP_SLL: begin
                sc_res = sll_full[WIDTH-1:0];
                sc_c   = sll_full[WIDTH];
            end
            OP_SLR:         sc_res = rot_res;
            OP_SRL: begin
                sc_res = srl_full[WIDTH:1];
                sc_c   = srl_full[0];
            end
            OP_SRA: begin
                sc_res = sra_res;
                sc_c   = srl_full[0];
            end
            default: ;
        endcase
    end

    // One multiplier step: work = {partial product high, remaining multiplier bits}
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_work;
    assign mul_sum  = {1'b0, work_reg[2*WIDTH-1:WIDTH]} + (work_reg[0] ? {1'b0, opnd_reg} : '0);
    assign mul_work = {mul_sum, work_reg[WIDTH-1:1]};

    // One restoring-divide step: work = {remainder, dividend/quotient shift register}
    logic [WIDTH:0]       div_shift;
    logic                 div_ok;
    logic [WIDTH-1:0]     div_rem;
    logic [2*WIDTH-1:0]   div_work;
    assign div_shift = {work_reg[2*WIDTH-1:WIDTH], work_reg[WIDTH-1]};
    assign div_ok    = (div_shift >= {1'b0, opnd_reg});
    assign div_rem   = div_ok ? (div_shift[WIDTH-1:0] - opnd_reg) : div_shift[WIDTH-1:0];
    assign div_work  = {div_rem, work_reg[WIDTH-2:0], div_ok};

    logic             fin;
    logic [WIDTH-1:0] fin_res;
    logic             fin_c, fin_v;

    always_comb begin
        state_next   = state_reg;
        op_next      = op_reg;
        opnd_next    = opnd_reg;
        work_next    = work_reg;
        count_next   = count_reg;
        alu_out_next = alu_out_reg;
        flag_next    = flag_reg;
        done_next    = 1'b0;
        fw_next      = 1'b0;
        fin          = 1'b0;
        fin_res      = '0;
        fin_c        = 1'b0;
        fin_v        = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (START) begin
                    op_next    = S_ALU;
                    count_next = '0;
                    if (S_ALU == OP_MUL) begin
                        state_next = ST_MUL;
                        opnd_next  = DATA_A;
                        work_next  = {{WIDTH{1'b0}}, DATA_B};
                    end else if (S_ALU == OP_DIV || S_ALU == OP_MOD) begin
                        state_next = ST_DIV;
                        opnd_next  = DATA_B;
                        work_next  = {{WIDTH{1'b0}}, DATA_A};
                    end else begin
                        fin     = 1'b1;
                        fin_res = sc_res;
                        fin_c   = sc_c;
                        fin_v   = sc_v;
                        fw_next = (S_ALU != OP_NON);
                    end
                end
            end
            ST_MUL: begin
                work_next  = mul_work;
                count_next = count_reg + SH_W'(1);
                if (count_reg == SH_W'(WIDTH - 1)) begin
                    state_next = ST_IDLE;
                    fin        = 1'b1;
                    fin_res    = mul_work[WIDTH-1:0];
                    fin_c      = |mul_work[2*WIDTH-1:WIDTH];
                    fw_next    = 1'b1;
                end
            end
            ST_DIV: begin
                work_next  = div_work;
                count_next = count_reg + SH_W'(1);
                if (count_reg == SH_W'(WIDTH - 1)) begin
                    state_next = ST_IDLE;
                    fin        = 1'b1;
                    fin_res    = (op_reg == OP_DIV) ? div_work[WIDTH-1:0] : div_work[2*WIDTH-1:WIDTH];
                    fin_v      = (opnd_reg == '0);
                    fw_next    = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        if (fin) begin
            alu_out_next = fin_res;
            flag_next    = {fin_res[WIDTH-1], (fin_res == '0), fin_c, fin_v};
            done_next    = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg   <= ST_IDLE;
            op_reg      <= '0;
            opnd_reg    <= '0;
            work_reg    <= '0;
            count_reg   <= '0;
            alu_out_reg <= '0;
            flag_reg    <= '0;
            done_reg    <= 1'b0;
            fw_reg      <= 1'b0;
        end else begin
            state_reg   <= state_next;
            op_reg      <= op_next;
            opnd_reg    <= opnd_next;
            work_reg    <= work_next;
            count_reg   <= count_next;
            alu_out_reg <= alu_out_next;
            flag_reg    <= flag_next;
            done_reg    <= done_next;
            fw_reg      <= fw_next;
        end
    end

    assign BUSY       = (state_reg != ST_IDLE);
    assign DONE       = done_reg;
    assign ALU_OUT    = alu_out_reg;
    assign FLAG_OUT   = flag_reg;
    assign FLAG_WRITE = fw_reg;
endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: the driver pushes expected results with their due cycle,
// a monitor checks DONE timing, BUSY, results, flags and held outputs every cycle.
module tb_seq_alu;
    localparam int W = 16;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         START = 1'b0;
    logic [3:0]   S_ALU = '0;
    logic [W-1:0] DATA_A = '0;
    logic [W-1:0] DATA_B = '0;
    logic         BUSY, DONE, FLAG_WRITE;
    logic [W-1:0] ALU_OUT;
    logic [3:0]   FLAG_OUT;

    seq_alu #(.WIDTH(W)) dut (
        .CLK(CLK), .RST(RST), .START(START), .S_ALU(S_ALU),
        .DATA_A(DATA_A), .DATA_B(DATA_B), .BUSY(BUSY), .DONE(DONE),
        .ALU_OUT(ALU_OUT), .FLAG_OUT(FLAG_OUT), .FLAG_WRITE(FLAG_WRITE)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] res;
        logic [3:0]   flg;
        logic         fw;
        int           acc;
        int           due;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    bit   stim_done = 1'b0;

    function automatic bit is_multi(input logic [3:0] op);
        return (op == 4'd7) || (op == 4'd13) || (op == 4'd14);
    endfunction

    // Reference model: plain integer arithmetic on the opcode's definition
    function automatic void model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] rr, output logic [3:0] f, output logic fw);
        longint unsigned ua, ub, p;
        longint          sa, ss;
        int              n;
        bit              c, v;
        ua = a; ub = b; n = int'(ub % W);
        c = 0; v = 0; rr = '0; fw = (op != 4'd15);
        case (op)
            4'd0: begin p = ua + ub; rr = p[W-1:0]; c = p[W];
                        v = (a[W-1] == b[W-1]) && (rr[W-1] != a[W-1]); end
            4'd1, 4'd5: begin rr = a - b; c = (ua < ub);
                        v = (a[W-1] != b[W-1]) && (rr[W-1] != a[W-1]); end
            4'd2: rr = a & b;
            4'd3: rr = a | b;
            4'd4: rr = a ^ b;
            4'd6, 4'd12: rr = b;
            4'd7: begin p = ua * ub; rr = p[W-1:0]; c = ((p >> W) != 0); end
            4'd8: begin p = ua << n; rr = p[W-1:0]; c = (n > 0) ? a[W-n] : 1'b0; end
            4'd9: begin p = (ua << n) | (ua >> (W - n)); rr = p[W-1:0]; end
            4'd10: begin rr = a >> n; c = (n > 0) ? a[n-1] : 1'b0; end
            4'd11: begin sa = $signed(a); ss = sa >>> n; rr = ss[W-1:0];
                         c = (n > 0) ? a[n-1] : 1'b0; end
            4'd13: begin if (ub == 0) rr = '1; else rr = a / b; v = (ub == 0); end
            4'd14: begin if (ub == 0) rr = a;  else rr = a % b; v = (ub == 0); end
            default: rr = '0;
        endcase
        f = {rr[W-1], (rr == '0), c, v};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h cycle=%0d", name, act, req, cyc);
        end
    endtask

    // Monitor: the only process that compares and counts
    initial begin
        exp_t         e;
        logic [W-1:0] hold_res;
        logic [3:0]   hold_flg;
        bit           exp_done, exp_busy;
        hold_res = '0;
        hold_flg = '0;
        forever begin
            @(negedge CLK or posedge RST);
            if (RST) begin
                #1;
                sb.delete();
                hold_res = '0;
                hold_flg = '0;
                check("rst_busy", BUSY, 0);
                check("rst_done", DONE, 0);
                check("rst_out", ALU_OUT, 0);
                check("rst_flag", FLAG_OUT, 0);
                check("rst_fw", FLAG_WRITE, 0);
            end else if (stim_done) begin
                check("sb_empty", sb.size(), 0);
                $display("Result: errors=%0d of %0d checks", errors, checks);
                $finish;
            end else begin
                exp_done = (sb.size() > 0) && (sb[0].due == cyc);
                exp_busy = (sb.size() > 0) && (sb[0].due > sb[0].acc) &&
                           (cyc >= sb[0].acc) && (cyc < sb[0].due);
                check("done_timing", DONE, exp_done);
                check("busy", BUSY, exp_busy);
                if (exp_done) begin
                    e = sb.pop_front();
                    $display("txn op=%h out=%h flags=%b fw=%b (model out=%h flags=%b)",
                             e.op, ALU_OUT, FLAG_OUT, FLAG_WRITE, e.res, e.flg);
                    check("result", ALU_OUT, e.res);
                    check("flags", FLAG_OUT, e.flg);
                    check("flag_write", FLAG_WRITE, e.fw);
                    hold_res = e.res;
                    hold_flg = e.flg;
                end else begin
                    check("hold_out", ALU_OUT, hold_res);
                    check("hold_flag", FLAG_OUT, hold_flg);
                    check("fw_idle", FLAG_WRITE, 0);
                end
            end
        end
    end

    // Issue one op; leaves START low with no edge in between so back-to-back calls chain
    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] r, input logic [3:0] f, input logic fw);
        exp_t e;
        S_ALU = op; DATA_A = a; DATA_B = b; START = 1'b1;
        e.op = op; e.res = r; e.flg = f; e.fw = fw;
        e.acc = cyc + 1;
        e.due = e.acc + (is_multi(op) ? W : 0);
        sb.push_back(e);
        @(posedge CLK); #1;
        if (is_multi(op)) begin
            for (int k = 0; k < W + 8; k++) begin
                if (!BUSY) break;
                START  = 1'($urandom_range(0, 1));
                S_ALU  = 4'($urandom);
                DATA_A = W'($urandom);
                DATA_B = W'($urandom);
                @(posedge CLK); #1;
            end
        end
        START = 1'b0;
    endtask

    task automatic issue_model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        logic [3:0]   f;
        logic         fw;
        model(op, a, b, r, f, fw);
        issue(op, a, b, r, f, fw);
    endtask

    task automatic idle(input int n);
        START = 1'b0;
        repeat (n) begin @(posedge CLK); #1; end
    endtask

    initial begin
        exp_t e;
        logic [3:0]   op;
        logic [W-1:0] a, b;
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;
        idle(2);

        issue(4'd0, 16'h7FFF, 16'h0001, 16'h8000, 4'b1001, 1'b1);
        issue(4'd1, 16'd100,  16'd200,  16'hFF9C, 4'b1010, 1'b1);
        idle(1);
        issue(4'd7, 16'd300,  16'd300,  16'h5F90, 4'b0010, 1'b1);
        issue(4'd13, 16'd100, 16'd7,    16'd14,   4'b0000, 1'b1);
        issue(4'd14, 16'd100, 16'd7,    16'd2,    4'b0000, 1'b1);
        issue(4'd13, 16'h1234, 16'h0000, 16'hFFFF, 4'b1001, 1'b1);
        issue(4'd14, 16'h1234, 16'h0000, 16'h1234, 4'b0001, 1'b1);
        issue(4'd9,  16'h8001, 16'd1,   16'h0003, 4'b0000, 1'b1);
        issue(4'd11, 16'h8001, 16'd1,   16'hC000, 4'b1010, 1'b1);
        issue(4'd8,  16'h8001, 16'd1,   16'h0002, 4'b0010, 1'b1);
        issue(4'd10, 16'h8001, 16'd0,   16'h8001, 4'b1000, 1'b1);
        idle(2);
        issue(4'd15, 16'h1234, 16'h5678, 16'h0000, 4'b0100, 1'b0);
        issue(4'd5,  16'd5,    16'd5,    16'h0000, 4'b0100, 1'b1);
        idle(2);
        issue(4'd0, 16'h7FFF, 16'h0001, 16'h8000, 4'b1001, 1'b1);
        idle(1);

        // Abort a MUL with an asynchronous reset in its fifth busy cycle
        S_ALU = 4'd7; DATA_A = 16'd300; DATA_B = 16'd300; START = 1'b1;
        e.op = 4'd7; e.res = 16'h5F90; e.flg = 4'b0010; e.fw = 1'b1;
        e.acc = cyc + 1; e.due = e.acc + W;
        sb.push_back(e);
        @(posedge CLK); #1 START = 1'b0;
        repeat (4) @(posedge CLK);
        #2 RST = 1'b1;
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;
        idle(W + 4);
        issue(4'd0, 16'd1, 16'd2, 16'd3, 4'b0000, 1'b1);
        idle(1);

        for (int i = 0; i < 150; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = W'($urandom);
            b  = W'($urandom);
            if ($urandom_range(0, 7) == 0) b = '0;
            if ($urandom_range(0, 7) == 0) a = '1;
            issue_model(op, a, b);
            idle($urandom_range(0, 2));
        end

        idle(W + 4);
        stim_done = 1'b1;
        repeat (4) @(posedge CLK);
        $display("FAIL monitor_stall: actual=running required=finished cycle=%0d", cyc);
        $fatal(1, "monitor did not finish");
    end
endmodule
